// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver: PS/2 frame receiver with make/break/extended scan-code decoding
module ps2_key_receiver #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic       ps2_key_pressed,
   output logic [7:0] ps2_key_data,
   output logic       ps2_key_extended,
   output logic       ps2_frame_error
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   state_t state;
   logic [2:0] ck_s;
   logic [1:0] dt_s;
   logic [2:0] cnt;
   logic [7:0] sr;
   logic par;
   logic [TW-1:0] tcnt;
   logic byte_vld;
   logic break_pending, ext_pending;
   logic fall, dat;
   assign fall = ck_s[2] & ~ck_s[1];
   assign dat = dt_s[1];
   always_ff @(posedge clock) begin
      if (reset) begin
         ck_s <= '1;
         dt_s <= '1;
         state <= IDLE;
         cnt <= '0;
         sr <= '0;
         par <= 1'b0;
         tcnt <= '0;
         byte_vld <= 1'b0;
         ps2_frame_error <= 1'b0;
      end else begin
         ck_s <= {ck_s[1:0], ps2_clk};
         dt_s <= {dt_s[0], ps2_dat};
         byte_vld <= 1'b0;
         ps2_frame_error <= 1'b0;
         tcnt <= (fall || state == IDLE) ? '0 : tcnt + 1'b1;
         if (fall) begin
            case (state)
               IDLE: begin
                  cnt <= '0;
                  state <= dat ? IDLE : DATA;
               end
               DATA: begin
                  sr <= {dat, sr[7:1]};
                  cnt <= cnt + 1'b1;
                  state <= (cnt == 3'd7) ? PARITY : DATA;
               end
               PARITY: begin
                  par <= dat;
                  state <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  byte_vld <= (^{sr, par}) & dat;
                  ps2_frame_error <= ~((^{sr, par}) & dat);
               end
            endcase
         end else if (state != IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state <= IDLE;
            ps2_frame_error <= 1'b1;
         end
      end
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         break_pending <= 1'b0;
         ext_pending <= 1'b0;
         ps2_key_pressed <= 1'b0;
         ps2_key_data <= '0;
         ps2_key_extended <= 1'b0;
      end else begin
         ps2_key_pressed <= 1'b0;
         if (ps2_frame_error) begin
            break_pending <= 1'b0;
            ext_pending <= 1'b0;
         end else if (byte_vld) begin
            if (sr == 8'hF0) break_pending <= 1'b1;
            else if (sr == 8'hE0) ext_pending <= 1'b1;
            else if (break_pending) begin
               break_pending <= 1'b0;
               ext_pending <= 1'b0;
            end else begin
               ps2_key_pressed <= 1'b1;
               ps2_key_data <= sr;
               ps2_key_extended <= ext_pending;
               ext_pending <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_ps2_key_receiver.sv
// tb_ps2_key_receiver: self-checking bench for ps2_key_receiver
module tb_ps2_key_receiver;
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic ps2_clk = 1'b1;
   logic ps2_dat = 1'b1;
   logic ps2_key_pressed, ps2_key_extended, ps2_frame_error;
   logic [7:0] ps2_key_data;
   ps2_key_receiver #(.TIMEOUT_CYCLES(100)) dut (
      .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
      .ps2_key_pressed(ps2_key_pressed), .ps2_key_data(ps2_key_data),
      .ps2_key_extended(ps2_key_extended), .ps2_frame_error(ps2_frame_error)
   );
   always #5 clock = ~clock;
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;
   int n_press = 0, n_err = 0, n_overlap = 0, n_hold = 0;
   int press_cyc = 0, err_cyc = 0, edge_cyc = 0;
   logic [8:0] prev = '0;
   always @(negedge clock) begin
      if (ps2_key_pressed) begin n_press++; press_cyc = cyc; end
      if (ps2_frame_error) begin n_err++; err_cyc = cyc; end
      if (ps2_key_pressed && ps2_frame_error) n_overlap++;
      if (!reset && !ps2_key_pressed && {ps2_key_extended, ps2_key_data} != prev) n_hold++;
      prev = {ps2_key_extended, ps2_key_data};
   end
   int total = 0, passed = 0;
   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask
   task automatic send_bit(input logic d, input bit mark = 1'b0);
      @(negedge clock);
      ps2_dat = d;
      repeat (4) @(negedge clock);
      ps2_clk = 1'b0;
      if (mark) edge_cyc = cyc;
      repeat (8) @(negedge clock);
      ps2_clk = 1'b1;
      repeat (3) @(negedge clock);
   endtask
   task automatic send_frame(input logic [7:0] b, input logic p, input logic s);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(p);
      send_bit(s, 1'b1);
      repeat (10) @(negedge clock);
   endtask
   logic m_brk, m_ext, m_kext;
   logic [7:0] m_data;
   task automatic model(input logic [7:0] b, input logic p, input logic s, output int ep, output int ee);
      ep = 0;
      ee = 0;
      if ((($countones(b) + int'(p)) % 2 != 1) || !s) begin
         ee = 1;
         m_brk = 0;
         m_ext = 0;
      end else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE0) m_ext = 1;
      else if (m_brk) begin
         m_brk = 0;
         m_ext = 0;
      end else begin
         ep = 1;
         m_data = b;
         m_kext = m_ext;
         m_ext = 0;
      end
   endtask
   typedef struct {
      logic [7:0] b;
      logic p, s;
      int press, err;
      logic [7:0] data;
      logic ext;
   } vec_t;
   vec_t tbl[18];
   initial begin
      int p0, e0, ep, ee;
      logic [7:0] b;
      logic p, s;
      tbl[0]  = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b0};
      tbl[1]  = '{8'hF0, 1'b1, 1'b1, 0, 0, 8'h1C, 1'b0};
      tbl[2]  = '{8'h1C, 1'b0, 1'b1, 0, 0, 8'h1C, 1'b0};
      tbl[3]  = '{8'hE0, 1'b0, 1'b1, 0, 0, 8'h1C, 1'b0};
      tbl[4]  = '{8'h75, 1'b0, 1'b1, 1, 0, 8'h75, 1'b1};
      tbl[5]  = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b0};
      tbl[6]  = '{8'h1C, 1'b1, 1'b1, 0, 1, 8'h1C, 1'b0};
      tbl[7]  = '{8'h1C, 1'b0, 1'b0, 0, 1, 8'h1C, 1'b0};
      tbl[8]  = '{8'hF0, 1'b1, 1'b1, 0, 0, 8'h1C, 1'b0};
      tbl[9]  = '{8'h1C, 1'b1, 1'b1, 0, 1, 8'h1C, 1'b0};
      tbl[10] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b0};
      tbl[11] = '{8'hE0, 1'b0, 1'b1, 0, 0, 8'h1C, 1'b0};
      tbl[12] = '{8'h75, 1'b1, 1'b1, 0, 1, 8'h1C, 1'b0};
      tbl[13] = '{8'h75, 1'b0, 1'b1, 1, 0, 8'h75, 1'b0};
      tbl[14] = '{8'hE0, 1'b0, 1'b1, 0, 0, 8'h75, 1'b0};
      tbl[15] = '{8'hF0, 1'b1, 1'b1, 0, 0, 8'h75, 1'b0};
      tbl[16] = '{8'h75, 1'b0, 1'b1, 0, 0, 8'h75, 1'b0};
      tbl[17] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b0};
      repeat (3) @(negedge clock);
      chk("reset_pressed", int'(ps2_key_pressed), 0);
      chk("reset_data", int'(ps2_key_data), 0);
      chk("reset_ext", int'(ps2_key_extended), 0);
      chk("reset_err", int'(ps2_frame_error), 0);
      reset = 1'b0;
      repeat (5) @(negedge clock);
      for (int i = 0; i < 18; i++) begin
         p0 = n_press;
         e0 = n_err;
         send_frame(tbl[i].b, tbl[i].p, tbl[i].s);
         chk($sformatf("tbl%0d_press", i), n_press - p0, tbl[i].press);
         chk($sformatf("tbl%0d_err", i), n_err - e0, tbl[i].err);
         chk($sformatf("tbl%0d_data", i), int'(ps2_key_data), int'(tbl[i].data));
         chk($sformatf("tbl%0d_ext", i), int'(ps2_key_extended), int'(tbl[i].ext));
         if (tbl[i].press != 0) chk($sformatf("tbl%0d_press_latency", i), press_cyc - edge_cyc, 4);
         if (tbl[i].err != 0) chk($sformatf("tbl%0d_err_latency", i), err_cyc - edge_cyc, 3);
      end
      p0 = n_press;
      e0 = n_err;
      send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      repeat (200) @(negedge clock);
      chk("timeout_err", n_err - e0, 1);
      chk("timeout_press", n_press - p0, 0);
      send_frame(8'h29, 1'b0, 1'b1);
      chk("after_timeout_press", n_press - p0, 1);
      chk("after_timeout_err", n_err - e0, 1);
      chk("after_timeout_data", int'(ps2_key_data), 8'h29);
      p0 = n_press;
      e0 = n_err;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      chk("midreset_data", int'(ps2_key_data), 0);
      chk("midreset_ext", int'(ps2_key_extended), 0);
      repeat (150) @(negedge clock);
      chk("midreset_press", n_press - p0, 0);
      chk("midreset_err", n_err - e0, 0);
      send_frame(8'h5A, 1'b1, 1'b1);
      chk("after_reset_press", n_press - p0, 1);
      chk("after_reset_data", int'(ps2_key_data), 8'h5A);
      chk("after_reset_ext", int'(ps2_key_extended), 0);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      m_brk = 0;
      m_ext = 0;
      m_kext = 0;
      m_data = '0;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 9))
            0, 1: b = 8'hF0;
            2, 3: b = 8'hE0;
            default: b = 8'($urandom_range(0, 255));
         endcase
         p = ~^b ^ ($urandom_range(0, 9) == 0);
         s = $urandom_range(0, 9) != 0;
         p0 = n_press;
         e0 = n_err;
         send_frame(b, p, s);
         model(b, p, s, ep, ee);
         chk($sformatf("rnd%0d_press", i), n_press - p0, ep);
         chk($sformatf("rnd%0d_err", i), n_err - e0, ee);
         chk($sformatf("rnd%0d_data", i), int'(ps2_key_data), int'(m_data));
         chk($sformatf("rnd%0d_ext", i), int'(ps2_key_extended), int'(m_kext));
      end
      chk("no_overlap", n_overlap, 0);
      chk("outputs_held", n_hold, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/ps2_key_receiver.md
PS2_KEY_RECEIVER -- requirements
Module: ps2_key_receiver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning the number of clock cycles without a PS/2 clock falling edge before a partial frame is abandoned.
REQ-002 SHALL have port clock, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port ps2_clk, input, 1, the raw PS/2 clock line, asynchronous to clock.
REQ-005 SHALL have port ps2_dat, input, 1, the raw PS/2 data line, asynchronous to clock.
REQ-006 SHALL have port ps2_key_pressed, output, 1, a one-cycle pulse marking delivery of a make code.
REQ-007 SHALL have port ps2_key_data, output, 8, the last delivered make code, held between pulses.
REQ-008 SHALL have port ps2_key_extended, output, 1, high when the last delivered code was E0-prefixed, held with ps2_key_data.
REQ-009 SHALL have port ps2_frame_error, output, 1, a one-cycle pulse on a parity error, stop-bit error or timeout.

Function
REQ-010 SHALL synchronize ps2_clk and ps2_dat through two flops each; SHALL detect a falling edge as a synchronized ps2_clk transition from 1 to 0, one cycle wide.
REQ-011 SHALL implement frame FSM states IDLE, DATA, PARITY, STOP; all sampling SHALL occur only on detected falling edges, using synchronized ps2_dat.
REQ-012 IDLE: on an edge with dat=0 (start bit), SHALL go to DATA with bit count 0; on an edge with dat=1, SHALL stay in IDLE with no error.
REQ-013 DATA: SHALL shift in 8 bits LSB first; SHALL go to PARITY after the 8th edge.
REQ-014 PARITY: SHALL capture the parity bit and go to STOP.
REQ-015 STOP: SHALL check the frame and return to IDLE; the frame is valid iff the XOR of 8 data bits and parity = 1 (odd parity) and stop bit = 1.
REQ-016 A valid frame SHALL hand its byte to the code decoder in the cycle after the STOP edge; an invalid frame SHALL pulse ps2_frame_error in that same cycle and deliver nothing.
REQ-017 Timeout counter: SHALL clear on every falling edge and while in IDLE; SHALL otherwise increment; on reaching TIMEOUT_CYCLES-1 outside IDLE, SHALL force IDLE and pulse ps2_frame_error on the next cycle.
REQ-018 Decoder state: SHALL keep two flags, break_pending and ext_pending.
REQ-019 Received byte 0xF0: SHALL set break_pending and produce no output.
REQ-020 Received byte 0xE0: SHALL set ext_pending and produce no output.
REQ-021 Any other byte with break_pending=1: SHALL clear both flags and produce no output, so break codes are fully suppressed.
REQ-022 Any other byte with break_pending=0: SHALL pulse ps2_key_pressed for one cycle, load ps2_key_data with the byte, load ps2_key_extended with ext_pending, and clear ext_pending.
REQ-023 Latency: ps2_key_pressed SHALL assert exactly 2 clock cycles after the cycle in which the STOP-bit falling edge is detected (one cycle frame check, one cycle decode).
REQ-024 Any frame error or timeout SHALL clear break_pending and ext_pending.
REQ-025 ps2_key_pressed and ps2_frame_error SHALL never be high in the same cycle; each SHALL be high for at most one cycle per frame.
REQ-026 ps2_key_data and ps2_key_extended SHALL change only in a cycle where ps2_key_pressed is asserted.

Reset
REQ-027 On reset, SHALL clear ps2_key_pressed, ps2_key_data, ps2_key_extended and ps2_frame_error to 0, put the FSM in IDLE, clear bit count, timeout counter and both decoder flags, and preset the synchronizer flops to 1 (idle bus).
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no pulse on any output; the first complete frame after reset is released SHALL decode normally.

Verification
REQ-029 Scenario 1: frame with data 0x1C, parity 0, stop 1 -> one ps2_key_pressed pulse, ps2_key_data=0x1C, ps2_key_extended=0, no ps2_frame_error.
REQ-030 Scenario 2: after scenario 1, frames 0xF0 then 0x1C -> no ps2_key_pressed; ps2_key_data stays 0x1C.
REQ-031 Scenario 3: frames 0xE0 then 0x75 (parity 0) -> one pulse, ps2_key_data=0x75, ps2_key_extended=1; a following frame 0x1C -> ps2_key_extended=0.
REQ-032 Scenario 4: frame 0x1C with parity 1, and separately a frame with stop bit 0 -> one ps2_frame_error pulse each, no ps2_key_pressed.
REQ-033 Scenario 5: start bit plus 5 data bits, then an idle line; TIMEOUT_CYCLES overridden to 100 -> ps2_frame_error pulses exactly once, the FSM returns to IDLE, and the next valid 0x29 frame delivers 0x29.
REQ-034 Scenario 6: reset pulsed after the 4th data bit of a frame -> all outputs 0, no pulses; the next valid 0x5A frame delivers 0x5A with extended=0.
